// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and its wait timer.
package apb_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 8;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; flags expiry on the ACCESS cycle that would reach TIMEOUT.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count_en && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The current stalled cycle is the TIMEOUT-th one when TIMEOUT-1 have already been counted.
    assign expired = (TIMEOUT > 0) && count_en && (r_cnt >= LAST_CNT);

endmodule

// File: rtl/apb_master_bridge.sv
// Request-bus to two-slave APB3 master with pslverr/timeout completion status.
//   state  | meaning
//   IDLE   | no transfer, waiting for transfer=1
//   SETUP  | psel asserted for one cycle, penable low
//   ACCESS | penable high, waiting for selected pready or timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready1,
    input  logic          pready2,
    input  logic [DW-1:0] prdata1,
    input  logic [DW-1:0] prdata2,
    input  logic          pslverr1,
    input  logic          pslverr2
);

    apb_state_e    r_state;
    apb_state_e    w_next;
    logic          r_pwrite;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_done;
    logic          r_err;

    logic          w_sel2;
    logic          w_pready;
    logic [DW-1:0] w_prdata;
    logic          w_pslverr;
    logic          w_count_en;
    logic          w_expired;
    logic          w_capture;
    logic          w_complete;
    logic          w_abort;

    assign w_sel2     = r_addr[AW-1];
    assign w_pready   = w_sel2 ? pready2  : pready1;
    assign w_prdata   = w_sel2 ? prdata2  : prdata1;
    assign w_pslverr  = w_sel2 ? pslverr2 : pslverr1;
    assign w_count_en = (r_state == ACCESS) && !w_pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk     (pclk),
        .preset   (preset),
        .clear    (r_state != ACCESS),
        .count_en (w_count_en),
        .expired  (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (transfer) begin
                    w_capture = 1'b1;
                    w_next    = SETUP;
                end
            end
            SETUP: begin
                w_next = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a simultaneous timeout.
                if (w_pready) begin
                    w_complete = 1'b1;
                    if (transfer) begin
                        w_capture = 1'b1;
                        w_next    = SETUP;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pwrite <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_complete || w_abort;
            r_err  <= (w_complete && w_pslverr) || w_abort;
            if (w_capture) begin
                r_pwrite <= ~read_write;
                r_addr   <= (read_write == RD) ? apb_read_paddr : apb_write_paddr;
                r_wdata  <= apb_write_data;
            end
            if (w_complete && !r_pwrite && !w_pslverr) begin
                r_rdata <= w_prdata;
            end
        end
    end

    assign psel1             = (r_state != IDLE) && !w_sel2;
    assign psel2             = (r_state != IDLE) &&  w_sel2;
    assign penable           = (r_state == ACCESS);
    assign pwrite            = r_pwrite;
    assign paddr             = r_addr;
    assign pwdata            = r_wdata;
    assign apb_read_data_out = r_rdata;
    assign xfer_done         = r_done;
    assign xfer_err          = r_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench: randomized requests, behavioural slaves, queue-based expectation checking.
module tb_apb_master_bridge;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;
    logic          xfer_done;
    logic          xfer_err;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready1;
    logic          pready2;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;
    logic          pslverr1;
    logic          pslverr2;

    apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .pclk              (pclk),
        .preset            (preset),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .xfer_done         (xfer_done),
        .xfer_err          (xfer_err),
        .psel1             (psel1),
        .psel2             (psel2),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .pready1           (pready1),
        .pready2           (pready2),
        .prdata1           (prdata1),
        .prdata2           (prdata2),
        .pslverr1          (pslverr1),
        .pslverr2          (pslverr2)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            n_acc;
        logic          err;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    typedef struct {
        int   w;
        logic err;
    } rsp_t;

    exp_t exp_q[$];
    exp_t fly_q[$];
    rsp_t rsp_q[$];

    logic [DW-1:0] model_mem [512];
    logic [DW-1:0] slv_mem   [512];
    logic [DW-1:0] model_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: completions first (a back-to-back SETUP shares the done cycle), then SETUP phases.
    always @(negedge pclk) begin
        exp_t e;
        if (!preset) begin
            if (xfer_done) begin
                if (fly_q.size() == 0) begin
                    chk("spurious_done", 32'(fly_q.size()), 1);
                end else begin
                    e = fly_q.pop_front();
                    chk("done_err", 32'(xfer_err), 32'(e.err));
                    chk("read_data", 32'(apb_read_data_out), 32'(e.rdata));
                    chk("done_latency", 32'(cyc), 32'(e.due));
                end
            end else begin
                chk("err_without_done", 32'(xfer_err), 0);
            end
            if ((psel1 || psel2) && !penable) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_setup", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("setup_paddr", 32'(paddr), 32'(e.addr));
                    chk("setup_pwrite", 32'(pwrite), 32'(e.wr));
                    chk("setup_pwdata", 32'(pwdata), 32'(e.wdata));
                    chk("setup_psel1", 32'(psel1), 32'(!e.addr[AW-1]));
                    chk("setup_psel2", 32'(psel2), 32'(e.addr[AW-1]));
                    e.due = cyc + e.n_acc + 1;
                    fly_q.push_back(e);
                end
            end
        end
    end

    // Behavioural slaves: the selected one follows the queued wait/error plan, everything else is noise.
    rsp_t cur_rsp;
    int   acnt = 0;
    always @(posedge pclk) begin
        #1;
        pready1  = 1'($urandom);
        pready2  = 1'($urandom);
        prdata1  = 8'($urandom);
        prdata2  = 8'($urandom);
        pslverr1 = 1'($urandom);
        pslverr2 = 1'($urandom);
        if ((psel1 || psel2) && !penable && rsp_q.size() > 0) begin
            cur_rsp = rsp_q.pop_front();
            acnt    = 0;
        end else if (penable) begin
            if (psel2) begin
                pready2 = (acnt == cur_rsp.w);
                prdata2 = slv_mem[paddr];
                if (acnt == cur_rsp.w) pslverr2 = cur_rsp.err;
            end else begin
                pready1 = (acnt == cur_rsp.w);
                prdata1 = slv_mem[paddr];
                if (acnt == cur_rsp.w) pslverr1 = cur_rsp.err;
            end
            if (acnt == cur_rsp.w && pwrite && !cur_rsp.err) slv_mem[paddr] = pwdata;
            acnt++;
        end
    end

    // Reference model: a transfer either times out (w >= TO) or finishes after w waits.
    task automatic issue(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int w, input logic err, input bit hold, output int cap_cyc);
        exp_t e;
        rsp_t r;
        bit   timed_out;
        bit   got;
        int   n;
        timed_out = (w >= TO);
        e.addr  = addr;
        e.wr    = !rd;
        e.wdata = wd;
        e.n_acc = timed_out ? TO : w + 1;
        e.err   = timed_out ? 1'b1 : err;
        if (!e.err) begin
            if (rd) model_rdata = model_mem[addr];
            else    model_mem[addr] = wd;
        end
        e.rdata = model_rdata;
        e.due   = 0;
        r.w     = w;
        r.err   = err;
        exp_q.push_back(e);
        rsp_q.push_back(r);
        transfer       = 1'b1;
        read_write     = rd;
        apb_write_data = wd;
        if (rd) begin
            apb_read_paddr  = addr;
            apb_write_paddr = 9'($urandom);
        end else begin
            apb_write_paddr = addr;
            apb_read_paddr  = 9'($urandom);
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge pclk);
            #1;
            if ((psel1 || psel2) && !penable) got = 1'b1;
        end
        if (!got) chk("capture_timeout", 32'(got), 1);
        cap_cyc = cyc;
        if (!hold) begin
            transfer = 1'b0;
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge pclk);
                #1;
            end
        end
    endtask

    task automatic drain();
        transfer = 1'b0;
        for (int i = 0; i < 300 && (exp_q.size() + fly_q.size()) > 0; i++) @(posedge pclk);
        repeat (2) @(posedge pclk);
        #1;
        chk("drain", 32'(exp_q.size() + fly_q.size()), 0);
    endtask

    initial begin
        int c, c1, c2, sel, w;
        for (int i = 0; i < 512; i++) begin
            model_mem[i] = 8'(i) ^ 8'h5A;
            slv_mem[i]   = 8'(i) ^ 8'h5A;
        end
        model_mem[9'h105] = 8'h3C;
        slv_mem[9'h105]   = 8'h3C;
        model_rdata     = '0;
        preset          = 1'b1;
        transfer        = 1'b0;
        read_write      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_psel", 32'({psel1, psel2, penable}), 0);
        chk("reset_status", 32'({xfer_done, xfer_err, pwrite}), 0);
        chk("reset_rdata", 32'(apb_read_data_out), 0);
        chk("reset_bus", 32'({paddr, pwdata}), 0);
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk);
        #1;

        issue(1'b0, 9'h012, 8'hA5, 0, 1'b0, 1'b0, c);
        issue(1'b1, 9'h105, 8'h00, 3, 1'b0, 1'b0, c);
        issue(1'b0, 9'h020, 8'h77, 0, 1'b0, 1'b1, c1);
        issue(1'b1, 9'h021, 8'h00, 0, 1'b0, 1'b0, c2);
        chk("b2b_setup_gap", 32'(c2 - c1), 2);
        issue(1'b1, 9'h105, 8'h00, 0, 1'b1, 1'b0, c);
        issue(1'b0, 9'h0AB, 8'h11, TO, 1'b0, 1'b0, c);
        issue(1'b0, 9'h0AC, 8'h22, TO - 1, 1'b0, 1'b0, c);
        issue(1'b1, 9'h0AC, 8'h00, 1, 1'b0, 1'b1, c);

        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            w   = (sel < 6) ? sel % 4 : (sel == 6) ? TO - 1 : (sel == 7) ? TO : 0;
            issue(1'($urandom), 9'($urandom), 8'($urandom), w,
                  ($urandom_range(0, 4) == 0), 1'($urandom), c);
        end
        drain();

        issue(1'b1, 9'h033, 8'h00, 10, 1'b0, 1'b0, c);
        @(posedge pclk);
        @(posedge pclk);
        #3;
        preset = 1'b1;
        #1;
        chk("midreset_psel", 32'({psel1, psel2, penable}), 0);
        chk("midreset_done", 32'({xfer_done, xfer_err}), 0);
        chk("midreset_rdata", 32'(apb_read_data_out), 0);
        exp_q.delete();
        fly_q.delete();
        rsp_q.delete();
        model_rdata = '0;
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk);
        #1;
        issue(1'b0, 9'h140, 8'h5E, 1, 1'b0, 1'b0, c);
        issue(1'b1, 9'h140, 8'h00, 0, 1'b0, 1'b0, c);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
